centroid_divider: RTL and testbench



---
 rtl/centroid_pkg.sv | 21 ++
 rtl/centroid_divider_if.sv | 32 +++
 rtl/centroid_div_serial.sv | 56 +++++
 rtl/centroid_divider.sv | 154 +++++++++++++++
 tb/tb_centroid_divider.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/centroid_pkg.sv
// Shared widths and FSM encoding for the centroid pipeline.
// Imported by the accumulator side and the divider block.
package centroid_pkg;

  localparam int STATE_WIDTH = 3;

  localparam int DEF_SUM_S_WIDTH  = 20;
  localparam int DEF_SUM_SX_WIDTH = 28;
  localparam int DEF_SUM_SY_WIDTH = 28;
  localparam int DEF_FRAC_BITS    = 4;
  localparam int DEF_COORD_WIDTH  = 11;

  typedef enum logic [STATE_WIDTH-1:0] {
    ST_IDLE  = 3'd0,
    ST_LATCH = 3'd1,
    ST_DIV_X = 3'd2,
    ST_DIV_Y = 3'd3,
    ST_OUT   = 3'd4
  } state_t;

endpackage

// File: rtl/centroid_divider_if.sv
// Result handshake between the centroid divider and the packetiser.
// The master drives the result and VALID, the slave drives READY.
interface centroid_divider_if #(
  parameter int OW = 15
);

  logic          oVALID;
  logic          iREADY;
  logic [OW-1:0] oX;
  logic [OW-1:0] oY;
  logic          oNO_TARGET;
  logic          oSAT;

  modport master (
    output oVALID,
    output oX,
    output oY,
    output oNO_TARGET,
    output oSAT,
    input  iREADY
  );

  modport slave (
    input  oVALID,
    input  oX,
    input  oY,
    input  oNO_TARGET,
    input  oSAT,
    output iREADY
  );

endinterface

// File: rtl/centroid_div_serial.sv
// Serial restoring divider, one quotient bit per clock, MSB first.
// oQUOT is complete during the single-cycle oDONE pulse.
module centroid_div_serial #(
  parameter int DW = 32
) (
  input  logic          CCLK,
  input  logic          RST_N,
  input  logic          iLOAD,
  input  logic [DW-1:0] iDIVIDEND,
  input  logic [DW-1:0] iDIVISOR,
  output logic [DW-1:0] oQUOT,
  output logic          oDONE
);

  localparam int CW = $clog2(DW + 1);

  logic [DW-1:0] r_rem;
  logic [DW-1:0] r_dvd;
  logic [DW-1:0] r_dvs;
  logic [DW-2:0] r_quot;
  logic [CW-1:0] r_cnt;

  logic [DW:0]   w_shift;
  logic          w_bit;

  assign w_shift = {r_rem, r_dvd[DW-1]};
  assign w_bit   = (w_shift >= {1'b0, r_dvs});

  always_ff @(posedge CCLK) begin
    if (!RST_N) begin
      r_rem  <= '0;
      r_dvd  <= '0;
      r_dvs  <= '0;
      r_quot <= '0;
      r_cnt  <= '0;
    end else if (iLOAD) begin
      r_rem  <= '0;
      r_dvd  <= iDIVIDEND;
      r_dvs  <= iDIVISOR;
      r_quot <= '0;
      r_cnt  <= CW'(DW);
    end else if (r_cnt != '0) begin
      r_rem  <= w_bit ? DW'(w_shift - {1'b0, r_dvs})
                      : w_shift[DW-1:0];
      r_dvd  <= {r_dvd[DW-2:0], 1'b0};
      r_quot <= {r_quot[DW-3:0], w_bit};
      r_cnt  <= r_cnt - CW'(1);
    end
  end

  // last bit is taken straight from the compare so the caller
  // can reload on the same edge it captures the quotient
  assign oQUOT = {r_quot, w_bit};
  assign oDONE = (r_cnt == CW'(1));

endmodule

// File: rtl/centroid_divider.sv
// Centroid X = Sx/S, Y = Sy/S in unsigned fixed point, using one
// shared serial divider sequenced X then Y.
module centroid_divider
  import centroid_pkg::*;
#(
  parameter int SUM_S_WIDTH  = DEF_SUM_S_WIDTH,
  parameter int SUM_SX_WIDTH = DEF_SUM_SX_WIDTH,
  parameter int SUM_SY_WIDTH = DEF_SUM_SY_WIDTH,
  parameter int FRAC_BITS    = DEF_FRAC_BITS,
  parameter int COORD_WIDTH  = DEF_COORD_WIDTH
) (
  input  logic                    CCLK,
  input  logic                    RST_N,
  input  logic                    iSTART_TRIG,
  input  logic [SUM_S_WIDTH-1:0]  iSUM_S,
  input  logic [SUM_SX_WIDTH-1:0] iSUM_SX,
  input  logic [SUM_SY_WIDTH-1:0] iSUM_SY,
  output logic                    oBUSY,
  output logic [STATE_WIDTH-1:0]  oSTATE,
  centroid_divider_if.master      res
);

  localparam int DW = SUM_SX_WIDTH + FRAC_BITS;
  localparam int OW = COORD_WIDTH + FRAC_BITS;
  localparam int ZW = DW - SUM_S_WIDTH;

  state_t r_state;
  state_t w_next;
  logic   r_trig_prev;
  logic   w_start;

  logic [SUM_S_WIDTH-1:0]  r_s;
  logic [SUM_SY_WIDTH-1:0] r_sy;
  logic [DW-1:0]           r_qx;
  logic [OW-1:0]           r_x;
  logic [OW-1:0]           r_y;
  logic                    r_nt;
  logic                    r_sat;

  logic          w_load;
  logic [DW-1:0] w_dividend;
  logic [DW-1:0] w_divisor;
  logic [DW-1:0] w_quot;
  logic          w_done;
  logic          w_s_zero;
  logic          w_ovf_x;
  logic          w_ovf_y;
  logic [OW-1:0] w_cx;
  logic [OW-1:0] w_cy;
  logic          w_busy;
  logic          w_valid;

  assign w_start  = iSTART_TRIG & ~r_trig_prev;
  assign w_s_zero = (iSUM_S == '0);

  always_ff @(posedge CCLK) begin
    if (!RST_N) begin
      r_state     <= ST_IDLE;
      r_trig_prev <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_trig_prev <= iSTART_TRIG;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_start) w_next = ST_LATCH;
      ST_LATCH: w_next = w_s_zero ? ST_OUT : ST_DIV_X;
      ST_DIV_X: if (w_done) w_next = ST_DIV_Y;
      ST_DIV_Y: if (w_done) w_next = ST_OUT;
      ST_OUT:   if (res.iREADY) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy  = (r_state != ST_IDLE);
    w_valid = (r_state == ST_OUT);
  end

  // X is loaded straight from the ports while the sums are latched
  assign w_load = ((r_state == ST_LATCH) && !w_s_zero)
               || ((r_state == ST_DIV_X) && w_done);

  always_comb begin
    w_dividend = {r_sy, {FRAC_BITS{1'b0}}};
    w_divisor  = {{ZW{1'b0}}, r_s};
    if (r_state == ST_LATCH) begin
      w_dividend = {iSUM_SX, {FRAC_BITS{1'b0}}};
      w_divisor  = {{ZW{1'b0}}, iSUM_S};
    end
  end

  centroid_div_serial #(.DW(DW)) u_div (
    .CCLK      (CCLK),
    .RST_N     (RST_N),
    .iLOAD     (w_load),
    .iDIVIDEND (w_dividend),
    .iDIVISOR  (w_divisor),
    .oQUOT     (w_quot),
    .oDONE     (w_done)
  );

  assign w_ovf_x = |r_qx[DW-1:OW];
  assign w_ovf_y = |w_quot[DW-1:OW];
  assign w_cx    = w_ovf_x ? '1 : r_qx[OW-1:0];
  assign w_cy    = w_ovf_y ? '1 : w_quot[OW-1:0];

  always_ff @(posedge CCLK) begin
    if (!RST_N) begin
      r_s   <= '0;
      r_sy  <= '0;
      r_qx  <= '0;
      r_x   <= '0;
      r_y   <= '0;
      r_nt  <= 1'b0;
      r_sat <= 1'b0;
    end else begin
      unique case (r_state)
        ST_LATCH: begin
          r_s  <= iSUM_S;
          r_sy <= iSUM_SY;
          if (w_s_zero) begin
            r_x   <= '0;
            r_y   <= '0;
            r_nt  <= 1'b1;
            r_sat <= 1'b0;
          end
        end
        ST_DIV_X: if (w_done) r_qx <= w_quot;
        ST_DIV_Y: begin
          if (w_done) begin
            r_x   <= w_cx;
            r_y   <= w_cy;
            r_nt  <= 1'b0;
            r_sat <= w_ovf_x | w_ovf_y;
          end
        end
        default: ;
      endcase
    end
  end

  assign oBUSY          = w_busy;
  assign oSTATE         = r_state;
  assign res.oVALID     = w_valid;
  assign res.oX         = r_x;
  assign res.oY         = r_y;
  assign res.oNO_TARGET = r_nt;
  assign res.oSAT       = r_sat;

endmodule

// File: tb/tb_centroid_divider.sv
// Bench for centroid_divider: vector table, directed corner
// sequences and random sums against an arithmetic model.
module tb_centroid_divider;
  import centroid_pkg::*;

  localparam int OW = DEF_COORD_WIDTH + DEF_FRAC_BITS;
  localparam longint OMAX = (64'd1 << OW) - 1;

  logic        clk;
  logic        rst_n;
  logic        trig;
  logic [19:0] sum_s;
  logic [27:0] sum_sx;
  logic [27:0] sum_sy;
  logic        busy;
  logic [2:0]  state;

  int n_checks;
  int n_err;

  centroid_divider_if #(.OW(OW)) res ();

  centroid_divider dut (
    .CCLK        (clk),
    .RST_N       (rst_n),
    .iSTART_TRIG (trig),
    .iSUM_S      (sum_s),
    .iSUM_SX     (sum_sx),
    .iSUM_SY     (sum_sy),
    .oBUSY       (busy),
    .oSTATE      (state),
    .res         (res)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    longint s;
    longint sx;
    longint sy;
    longint ex;
    longint ey;
    bit     nt;
    bit     sat;
    int     hold;
    bit     midtrig;
  } vec_t;

  task automatic check(input string name, input longint act,
                       input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // truncating fixed-point quotient, clamped to the output range
  function automatic void model(input longint s, sx, sy,
                                output longint ex, ey,
                                output bit nt, sat);
    longint qx, qy;
    if (s == 0) begin
      ex = 0; ey = 0; nt = 1; sat = 0;
    end else begin
      qx  = (sx * 16) / s;
      qy  = (sy * 16) / s;
      nt  = 0;
      sat = (qx > OMAX) || (qy > OMAX);
      ex  = (qx > OMAX) ? OMAX : qx;
      ey  = (qy > OMAX) ? OMAX : qy;
    end
  endfunction

  task automatic run(input vec_t v);
    int k;
    bit got;
    int nv;
    @(negedge clk);
    check("idle_busy", busy, 0);
    sum_s  = v.s[19:0];
    sum_sx = v.sx[27:0];
    sum_sy = v.sy[27:0];
    res.iREADY = (v.hold == 0);
    trig = 1'b1;
    k = 0;
    got = 0;
    while (!got && k < 200) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        trig = 1'b0;
        check("busy_t1", busy, 1);
        check("state_t1", state, 1);
      end
      if (res.oVALID) got = 1;
    end
    check("valid_latency", k, (v.s == 0) ? 2 : 66);
    if (!got) return;
    check("x", res.oX, v.ex);
    check("y", res.oY, v.ey);
    check("no_target", res.oNO_TARGET, v.nt);
    check("sat", res.oSAT, v.sat);
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      trig = v.midtrig && (i == v.hold / 2);
      check("hold_valid", res.oVALID, 1);
      check("hold_busy", busy, 1);
      check("hold_x", res.oX, v.ex);
      check("hold_y", res.oY, v.ey);
      check("hold_flags", {res.oNO_TARGET, res.oSAT},
            {v.nt, v.sat});
      if (i == v.hold - 1) res.iREADY = 1'b1;
    end
    trig = 1'b0;
    @(negedge clk);
    check("post_valid", res.oVALID, 0);
    check("post_busy", busy, 0);
    check("post_state", state, 0);
    res.iREADY = 1'b0;
    if (v.midtrig) begin
      nv = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (res.oVALID || busy) nv++;
      end
      check("no_second_result", nv, 0);
    end
  endtask

  vec_t tbl[$];
  vec_t rv;

  initial begin
    int nv;
    int k;
    n_checks = 0;
    n_err = 0;
    rst_n = 1'b0;
    trig = 1'b0;
    sum_s = '0;
    sum_sx = '0;
    sum_sy = '0;
    res.iREADY = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", res.oVALID, 0);
    check("rst_state", state, 0);
    check("rst_xy", {res.oX, res.oY}, 0);
    check("rst_flags", {res.oNO_TARGET, res.oSAT}, 0);
    rst_n = 1'b1;

    tbl.push_back('{100, 32000, 24000, 5120, 3840, 0, 0, 3, 0});
    tbl.push_back('{3, 10, 1, 53, 5, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 1, 0, 2, 0});
    tbl.push_back('{7, 100, 50, 228, 114, 0, 0, 0, 0});
    tbl.push_back('{1, 2047, 2048, 32752, 32767, 0, 1, 1, 0});
    tbl.push_back('{16, 32767, 0, 32767, 0, 0, 0, 0, 0});
    tbl.push_back('{1048575, 268435455, 0, 4096, 0, 0, 0, 0, 0});
    tbl.push_back('{100, 32000, 24000, 5120, 3840, 0, 0, 100, 1});
    foreach (tbl[i]) run(tbl[i]);

    // trigger held high: exactly one result, then a saturated X
    @(negedge clk);
    sum_s = 20'd1;
    sum_sx = 28'hFFFFFFF;
    sum_sy = 28'd7;
    res.iREADY = 1'b1;
    trig = 1'b1;
    nv = 0;
    for (int i = 0; i < 591; i++) begin
      @(negedge clk);
      if (i == 510) trig = 1'b0;
      if (res.oVALID) begin
        nv++;
        check("held_x", res.oX, 32767);
        check("held_y", res.oY, 112);
        check("held_sat", res.oSAT, 1);
      end
    end
    check("held_results", nv, 1);
    res.iREADY = 1'b0;

    // reset in the middle of the Y divide
    @(negedge clk);
    sum_s = 20'd100;
    sum_sx = 28'd32000;
    sum_sy = 28'd24000;
    trig = 1'b1;
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      trig = 1'b0;
    end
    check("mid_state", state, 3);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_valid", res.oVALID, 0);
    check("rst_mid_state", state, 0);
    run('{100, 32000, 24000, 5120, 3840, 0, 0, 0, 0});

    for (int n = 0; n < 30; n++) begin
      rv.s  = ($urandom_range(0, 7) == 0) ? 0 :
              ($urandom_range(0, 1) == 1) ?
              longint'($urandom_range(1, 50)) :
              longint'($urandom_range(1, 20'hFFFFF));
      rv.sx = longint'($urandom() >> $urandom_range(4, 31));
      rv.sy = longint'($urandom() >> $urandom_range(4, 31));
      rv.hold = $urandom_range(0, 5);
      rv.midtrig = 0;
      model(rv.s, rv.sx, rv.sy, rv.ex, rv.ey, rv.nt, rv.sat);
      run(rv);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
